// File: rtl/demux2.sv
// Two-way four-phase bundled-data demultiplexer: one data token plus one
// selector token yields one output token on the selected output channel.
module demux2 #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         r_i,
  output logic         a_i,
  input  logic [N-1:0] d_i,
  input  logic         rctl_i,
  input  logic         dctl_i,
  output logic         actl_i,
  output logic         r_o,
  input  logic         a_o,
  output logic [N-1:0] d_o,
  output logic         r1_o,
  input  logic         a1_o,
  output logic [N-1:0] d1_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t        state;
  logic          sel;
  logic [N-1:0]  data;
  logic          sel_ack;

  // Only the ack of the steered output matters; the other one is ignored.
  assign sel_ack = sel ? a1_o : a_o;

  assign d_o  = data;
  assign d1_o = data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= 1'b0;
      data   <= '0;
      a_i    <= 1'b0;
      actl_i <= 1'b0;
      r_o    <= 1'b0;
      r1_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (r_i && rctl_i) begin
            data  <= d_i;
            sel   <= dctl_i;
            r_o   <= ~dctl_i;
            r1_o  <= dctl_i;
            state <= SEND;
          end
        end
        SEND: begin
          if (sel_ack) begin
            r_o    <= 1'b0;
            r1_o   <= 1'b0;
            a_i    <= 1'b1;
            actl_i <= 1'b1;
            state  <= ACK;
          end
        end
        ACK: begin
          // Return to zero only once all three channels have released.
          if (!r_i && !rctl_i && !sel_ack) begin
            a_i    <= 1'b0;
            actl_i <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          a_i    <= 1'b0;
          actl_i <= 1'b0;
          r_o    <= 1'b0;
          r1_o   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux2.sv
// Self-checking bench for demux2: directed handshake scenarios with literal
// expectations plus a token-level reference model compared every cycle.
module tb_demux2;

  localparam int N = 8;

  logic         clk;
  logic         rst;
  logic         r_i, rctl_i, dctl_i, a_o, a1_o;
  logic [N-1:0] d_i;
  logic         a_i, actl_i, r_o, r1_o;
  logic [N-1:0] d_o, d1_o;

  int tests = 0;
  int fails = 0;
  bit checking = 0;

  demux2 #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .r_i(r_i), .a_i(a_i), .d_i(d_i),
    .rctl_i(rctl_i), .dctl_i(dctl_i), .actl_i(actl_i),
    .r_o(r_o), .a_o(a_o), .d_o(d_o),
    .r1_o(r1_o), .a1_o(a1_o), .d1_o(d1_o)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Token-level model: a token is either absent, waiting for its consumer,
  // or delivered and waiting for every channel to return to zero.
  bit           tokHeld, tokDelivered, tokSel;
  logic [N-1:0] tokData;

  always @(posedge clk) begin
    if (rst) begin
      tokHeld = 0; tokDelivered = 0; tokSel = 0; tokData = '0;
    end else if (!tokHeld) begin
      if (r_i && rctl_i) begin
        tokHeld = 1; tokDelivered = 0; tokSel = dctl_i; tokData = d_i;
      end
    end else if (!tokDelivered) begin
      if ((tokSel == 1'b0 && a_o) || (tokSel == 1'b1 && a1_o)) tokDelivered = 1;
    end else begin
      if (!r_i && !rctl_i && !(tokSel ? a1_o : a_o)) tokHeld = 0;
    end
  end

  // Compare DUT outputs against the model on every falling edge once reset has been seen.
  always @(negedge clk) begin
    logic [2*N+3:0] expv, actv;
    if (checking) begin
      expv = {tokHeld && !tokDelivered && !tokSel, tokHeld && !tokDelivered && tokSel,
              tokHeld && tokDelivered, tokHeld && tokDelivered, tokData, tokData};
      actv = {r_o, r1_o, a_i, actl_i, d_o, d1_o};
      tests++;
      if (actv !== expv) begin
        fails++;
        $display("[TB] FAIL model cycle t=%0t got {r_o,r1_o,a_i,actl_i,d_o,d1_o}=%h want %h",
                 $time, actv, expv);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s got %h want %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic rc, input logic dc,
                               input logic [N-1:0] d, input logic ao, input logic a1);
    r_i = r; rctl_i = rc; dctl_i = dc; d_i = d; a_o = ao; a1_o = a1;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic checkHs(input string name, input logic er0, input logic er1, input logic eack);
    checkOutput({name, " r_o"}, {15'd0, r_o}, {15'd0, er0});
    checkOutput({name, " r1_o"}, {15'd0, r1_o}, {15'd0, er1});
    checkOutput({name, " a_i"}, {15'd0, a_i}, {15'd0, eack});
    checkOutput({name, " actl_i"}, {15'd0, actl_i}, {15'd0, eack});
  endtask

  initial begin
    logic [N-1:0] seq [4];
    seq[0] = 8'h01; seq[1] = 8'h82; seq[2] = 8'h43; seq[3] = 8'hC4;

    rst = 1;
    applyStimulus(0, 0, 0, '0, 0, 0);
    nextCycle();
    nextCycle();
    checking = 1;
    checkHs("reset", 0, 0, 0);
    checkOutput("reset d_o", {8'd0, d_o}, 16'h0000);
    rst = 0;

    // Route to output 0, ack one cycle after the request.
    applyStimulus(1, 1, 0, 8'hA5, 0, 0);
    nextCycle();
    checkHs("r0 send", 1, 0, 0);
    checkOutput("r0 d_o", {8'd0, d_o}, 16'h00A5);
    nextCycle();
    checkHs("r0 wait", 1, 0, 0);
    a_o = 1;
    nextCycle();
    checkHs("r0 ack", 0, 0, 1);
    applyStimulus(0, 0, 0, 8'h00, 0, 0);
    nextCycle();
    checkHs("r0 rtz", 0, 0, 0);
    checkOutput("r0 data held", {8'd0, d_o}, 16'h00A5);

    // Route to output 1 while a_o pulses uselessly.
    applyStimulus(1, 1, 1, 8'h3C, 0, 0);
    nextCycle();
    checkHs("r1 send", 0, 1, 0);
    checkOutput("r1 d1_o", {8'd0, d1_o}, 16'h003C);
    a_o = 1;
    nextCycle();
    checkHs("r1 ignore a_o", 0, 1, 0);
    a_o = 0; a1_o = 1;
    nextCycle();
    checkHs("r1 ack", 0, 0, 1);
    applyStimulus(0, 0, 1, 8'h00, 0, 0);
    nextCycle();
    checkHs("r1 rtz", 0, 0, 0);

    // Only the data request is up for five cycles.
    applyStimulus(1, 0, 0, 8'h11, 0, 0);
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      checkHs("partial", 0, 0, 0);
    end
    rctl_i = 1;
    nextCycle();
    checkHs("partial capture", 1, 0, 0);
    checkOutput("partial d_o", {8'd0, d_o}, 16'h0011);
    a_o = 1;
    nextCycle();
    checkHs("stagger enter", 0, 0, 1);

    // Staggered release: r_i at +1, a_o at +3, rctl_i at +6.
    for (int i = 1; i <= 7; i++) begin
      nextCycle();
      checkHs("stagger", 0, 0, (i < 7) ? 1'b1 : 1'b0);
      if (i == 1) r_i = 0;
      if (i == 3) a_o = 0;
      if (i == 6) rctl_i = 0;
    end

    // Reset while output 1 is being offered a token.
    applyStimulus(1, 1, 1, 8'h77, 0, 0);
    nextCycle();
    checkHs("pre-reset", 0, 1, 0);
    rst = 1;
    nextCycle();
    checkHs("mid reset", 0, 0, 0);
    checkOutput("mid reset d1_o", {8'd0, d1_o}, 16'h0000);
    rst = 0;
    applyStimulus(0, 0, 0, 8'h00, 0, 0);
    nextCycle();
    applyStimulus(1, 1, 1, 8'h5A, 0, 0);
    nextCycle();
    checkHs("post reset", 0, 1, 0);
    checkOutput("post reset d1_o", {8'd0, d1_o}, 16'h005A);
    a1_o = 1;
    nextCycle();
    checkHs("post reset ack", 0, 0, 1);
    applyStimulus(0, 0, 0, 8'h00, 0, 0);
    nextCycle();

    // Back-to-back tokens with instantly responding neighbours, 3 cycles each.
    for (int t = 0; t < 4; t++) begin
      applyStimulus(1, 1, t[0], seq[t], 0, 0);
      nextCycle();
      checkHs($sformatf("b2b%0d send", t), ~t[0], t[0], 0);
      checkOutput($sformatf("b2b%0d data", t), {8'd0, (t[0] ? d1_o : d_o)}, {8'd0, seq[t]});
      if (t[0]) a1_o = 1; else a_o = 1;
      nextCycle();
      checkHs($sformatf("b2b%0d ack", t), 0, 0, 1);
      applyStimulus(0, 0, 0, 8'h00, 0, 0);
      nextCycle();
      checkHs($sformatf("b2b%0d rtz", t), 0, 0, 0);
    end

    nextCycle();
    checking = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
